bus_rr_router: RTL

Parametrised single-bus arbiter/router connecting DRVRS driver FIFOs. Each transaction follows the same sequence:
- Grant one pending driver using round-robin.
- Pop one packet from that driver.
- Decode the destination field in the packet MSBs.
- Push the packet to one target, or to all other drivers on broadcast.

Generalises the bus generator/arbiter with fair arbitration, per-source enable masking, self/invalid-address dropping, and a drop counter.

---
 rtl/bus_rr_router.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bus_rr_router.sv
// Single-bus round-robin arbiter/router: grants one pending driver, pops one
// packet, and pushes it to the addressed driver or to all others on broadcast.
module bus_rr_router #(
  parameter int                 DRVRS     = 4,
  parameter int                 PCKG_SZ   = 16,
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BROADCAST = {ADDR_W{1'b1}},
  localparam int                IDW       = (DRVRS > 1) ? $clog2(DRVRS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  input  logic [DRVRS-1:0]           src_en,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 state_dbg
);

  // Handshake: pndng is the driver's valid and pop is its ready; a word moves
  // in the GRANT cycle when both are high. push is a one-cycle valid with no
  // backpressure, qualifying whatever D_push carries in that cycle.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      pick;
  logic                pick_found;
  logic [PCKG_SZ-1:0]  pkt;
  logic [15:0]         drop_q;
  logic                drop_now;
  logic [DRVRS-1:0]    req;
  logic [DRVRS-1:0]    one_g;
  logic [DRVRS-1:0]    one_dest;
  logic [ADDR_W-1:0]   dest;
  logic                dest_in_range;

  assign req           = pndng & src_en;
  assign one_g         = DRVRS'(1) << grant_id;
  assign dest          = pkt[PCKG_SZ-1 -: ADDR_W];
  assign one_dest      = DRVRS'(1) << dest;
  assign dest_in_range = int'(dest) < DRVRS;
  assign D_push        = {DRVRS{pkt}};
  assign drop_cnt      = drop_q;
  assign state_dbg     = state;

  // Search starts one past the last served driver and wraps.
  always_comb begin
    pick       = ptr;
    pick_found = 1'b0;
    for (int k = 1; k <= DRVRS; k++) begin
      if (!pick_found && req[IDW'((int'(ptr) + k) % DRVRS)]) begin
        pick_found = 1'b1;
        pick       = IDW'((int'(ptr) + k) % DRVRS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found)       state_nxt = GRANT;
      GRANT:   if (pndng[grant_id])  state_nxt = DELIVER;
               else                  state_nxt = IDLE;
      DELIVER:                       state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = '0;
    push     = '0;
    drop_now = 1'b0;
    busy     = (state != IDLE);
    case (state)
      GRANT: begin
        // A driver that emptied after being granted is simply skipped.
        if (pndng[grant_id]) pop = one_g;
      end
      DELIVER: begin
        if (dest == BROADCAST)
          push = ~one_g;
        else if (dest_in_range && (int'(dest) != int'(grant_id)))
          push = one_dest;
        else
          drop_now = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= IDW'(DRVRS - 1);
      grant_id <= '0;
      pkt      <= '0;
      drop_q   <= '0;
    end else begin
      if (state == IDLE && pick_found)
        grant_id <= pick;
      if (state == GRANT && pndng[grant_id]) begin
        pkt <= D_pop[int'(grant_id)*PCKG_SZ +: PCKG_SZ];
        ptr <= grant_id;
      end
      if (drop_now && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

endmodule
